// File: rtl/alu_multicycle_pkg.sv
// Shared constants for the multicycle ALU: bus widths, opcode map, FSM encoding.
package alu_multicycle_pkg;

  localparam int DATA_BUS_WIDTH  = 64;
  localparam int ALU_OP_NUM_BITS = 4;

  // Opcode map; codes 10..15 are unassigned and flagged illegal.
  localparam int ALU_ADD     = 0;
  localparam int ALU_ABSDIFF = 1;
  localparam int ALU_AND     = 2;
  localparam int ALU_OR      = 3;
  localparam int ALU_XOR     = 4;
  localparam int ALU_SLL     = 5;
  localparam int ALU_SRL     = 6;
  localparam int ALU_SLT     = 7;
  localparam int ALU_MULU    = 8;
  localparam int ALU_DIVU    = 9;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MUL  = 3'd2,
    ST_DIV  = 3'd3,
    ST_DONE = 3'd4
  } alu_state_e;

endpackage

// File: rtl/alu_multicycle_muldiv.sv
// Shared iterative datapath: shift-add multiply / restoring divide, one bit per cycle.
// Accumulator layout: multiply {partial_hi, multiplier_lo}; divide {remainder, quotient}.
module alu_muldiv_iter #(
  parameter int WIDTH    = 64,
  parameter int CNT_BITS = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_run,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [CNT_BITS-1:0] r_cnt;
  logic               r_div;

  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_div_nxt;

  // One iteration step for each mode. Divide by zero needs no special case:
  // every trial subtract succeeds (quotient all ones) and the remainder
  // shifts in the whole dividend.
  always_comb begin
    w_add     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : '0)};
    w_mul_nxt = {w_add, r_acc[WIDTH-1:1]};
    w_trial   = r_acc[2*WIDTH-1:WIDTH-1];
    w_ge      = (w_trial >= {1'b0, r_b});
    w_sub     = w_trial[WIDTH-1:0] - r_b;
    w_rem     = w_ge ? w_sub : w_trial[WIDTH-1:0];
    w_div_nxt = {w_rem, r_acc[WIDTH-2:0], w_ge};
  end

  // Load on accept, then iterate until the down-counter reaches zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_div <= 1'b0;
    end else if (i_load) begin
      r_acc <= {{WIDTH{1'b0}}, i_a};
      r_b   <= i_b;
      r_cnt <= CNT_BITS'(WIDTH);
      r_div <= i_div;
    end else if (o_run) begin
      r_acc <= r_div ? w_div_nxt : w_mul_nxt;
      r_cnt <= r_cnt - CNT_BITS'(1);
    end
  end

  assign o_run = (r_cnt != '0);
  assign o_lo  = r_acc[WIDTH-1:0];
  assign o_hi  = r_acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/arith ops plus iterative MULU/DIVU behind
// a start/busy/done handshake. All result flags are registered with result.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH    = DATA_BUS_WIDTH,
  parameter int OP_BITS  = ALU_OP_NUM_BITS,
  parameter int CNT_BITS = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [OP_BITS-1:0] alu_op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   result_hi,
  output logic               zero,
  output logic               branch_le,
  output logic               div_by_zero,
  output logic               illegal_op
);

  localparam int SH_BITS = $clog2(WIDTH);

  alu_state_e r_state, w_state_nxt;

  logic [OP_BITS-1:0] r_op;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [WIDTH-1:0]   r_result, r_result_hi;
  logic               r_zero, r_branch_le, r_dbz, r_illegal;

  logic               w_accept, w_iter_load, w_iter_div, w_iter_run, w_out_we;
  logic [WIDTH-1:0]   w_iter_lo, w_iter_hi;
  logic [WIDTH-1:0]   w_diff, w_abs, w_res, w_res_hi;
  logic [SH_BITS-1:0] w_sh;
  logic               w_ble, w_dbz, w_ill;

  alu_muldiv_iter #(.WIDTH(WIDTH), .CNT_BITS(CNT_BITS)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_iter_load),
    .i_div  (w_iter_div),
    .i_a    (src_a),
    .i_b    (src_b),
    .o_run  (w_iter_run),
    .o_lo   (w_iter_lo),
    .o_hi   (w_iter_hi)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, accept and iterator load; start is only seen in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_iter_load = 1'b0;
    w_iter_div  = 1'b0;
    w_out_we    = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_accept = 1'b1;
        if (alu_op == OP_BITS'(ALU_MULU)) begin
          w_iter_load = 1'b1;
          w_state_nxt = ST_MUL;
        end else if (alu_op == OP_BITS'(ALU_DIVU)) begin
          w_iter_load = 1'b1;
          w_iter_div  = 1'b1;
          w_state_nxt = ST_DIV;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_out_we    = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_MUL, ST_DIV: if (!w_iter_run) begin
        w_out_we    = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture at accept; later operand changes are invisible.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= alu_op;
      r_a  <= src_a;
      r_b  <= src_b;
    end
  end

  // Result selection: single-cycle ops in EXEC, iterator output otherwise.
  always_comb begin
    w_res    = '0;
    w_res_hi = '0;
    w_ble    = 1'b0;
    w_dbz    = 1'b0;
    w_ill    = 1'b0;
    w_diff   = r_a - r_b;
    w_abs    = w_diff[WIDTH-1] ? ('0 - w_diff) : w_diff;
    w_sh     = r_b[SH_BITS-1:0];
    if (r_state == ST_MUL) begin
      w_res    = w_iter_lo;
      w_res_hi = w_iter_hi;
    end else if (r_state == ST_DIV) begin
      w_res    = w_iter_lo;
      w_res_hi = w_iter_hi;
      w_dbz    = (r_b == '0);
    end else begin
      case (r_op)
        OP_BITS'(ALU_ADD):     w_res = r_a + r_b;
        OP_BITS'(ALU_ABSDIFF): begin
          w_res = w_abs;
          w_ble = (w_abs <= r_b);
        end
        OP_BITS'(ALU_AND):     w_res = r_a & r_b;
        OP_BITS'(ALU_OR):      w_res = r_a | r_b;
        OP_BITS'(ALU_XOR):     w_res = r_a ^ r_b;
        OP_BITS'(ALU_SLL):     w_res = r_a << w_sh;
        OP_BITS'(ALU_SRL):     w_res = r_a >> w_sh;
        OP_BITS'(ALU_SLT):     w_res = WIDTH'($signed(r_a) < $signed(r_b));
        default:               w_ill = 1'b1;
      endcase
    end
  end

  // Output registers hold from one completion to the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_branch_le <= 1'b0;
      r_dbz       <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_out_we) begin
      r_result    <= w_res;
      r_result_hi <= w_res_hi;
      r_zero      <= (w_res == '0);
      r_branch_le <= w_ble;
      r_dbz       <= w_dbz;
      r_illegal   <= w_ill;
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign result      = r_result;
  assign result_hi   = r_result_hi;
  assign zero        = r_zero;
  assign branch_le   = r_branch_le;
  assign div_by_zero = r_dbz;
  assign illegal_op  = r_illegal;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at WIDTH=16.
module tb_alu_multicycle;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    alu_op = '0;
  logic [W-1:0]  src_a = '0, src_b = '0;
  logic          busy, done, zero, branch_le, div_by_zero, illegal_op;
  logic [W-1:0]  result, result_hi;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] res, hi;
    logic         z, ble, dbz, ill;
    int           acc;
  } exp_t;

  exp_t sb[$];

  alu_multicycle #(.WIDTH(W), .OP_BITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .result(result), .result_hi(result_hi), .zero(zero),
    .branch_le(branch_le), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0]   d;
    logic [2*W-1:0] p;
    e.op = op; e.res = '0; e.hi = '0; e.ble = 0; e.dbz = 0; e.ill = 0; e.acc = 0;
    case (op)
      4'd0: e.res = a + b;
      4'd1: begin
        d = a - b;
        e.res = d[W-1] ? (~d + 16'd1) : d;
        e.ble = (e.res <= b);
      end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = a << b[3:0];
      4'd6: e.res = a >> b[3:0];
      4'd7: e.res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'd8: begin
        p = {16'd0, a} * {16'd0, b};
        e.res = p[W-1:0];
        e.hi  = p[2*W-1:W];
      end
      4'd9: begin
        if (b == 0) begin
          e.res = 16'hFFFF; e.hi = a; e.dbz = 1;
        end else begin
          e.res = a / b; e.hi = a % b;
        end
      end
      default: e.ill = 1;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Raw one-cycle start pulse, no expectation pushed.
  task automatic pulse(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    alu_op = op; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; src_a = ~a; src_b = ~b;
  endtask

  // Wait for idle, push expectation, issue request.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("idle_timeout", 1, 0);
    e = model(op, a, b);
    e.acc = cyc + 1;
    sb.push_back(e);
    alu_op = op; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; src_a = ~a; src_b = ~b;
  endtask

  // Completion monitor: pop expectation on every done.
  always @(posedge clk) begin
    exp_t e;
    string s;
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        s = $sformatf("op%0d", e.op);
        chk({s, " result"}, result, e.res);
        chk({s, " result_hi"}, result_hi, e.hi);
        chk({s, " zero"}, zero, e.z);
        chk({s, " branch_le"}, branch_le, e.ble);
        chk({s, " div_by_zero"}, div_by_zero, e.dbz);
        chk({s, " illegal_op"}, illegal_op, e.ill);
        chk({s, " latency"}, cyc - e.acc + 1, (e.op == 8 || e.op == 9) ? W + 2 : 2);
      end
    end
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst result_hi", result_hi, 0);
    chk("rst flags", {zero, branch_le, div_by_zero, illegal_op}, 0);
    reset = 1'b0;

    issue(0, 16'hFFFF, 16'h0001);
    issue(1, 16'd3, 16'd10);
    issue(1, 16'd30, 16'd10);
    issue(7, 16'h8000, 16'h0001);
    issue(7, 16'h0001, 16'h8000);
    issue(5, 16'h0001, 16'h0013);
    issue(6, 16'h8000, 16'h00FF);
    issue(2, 16'hF0F0, 16'h3C3C);
    issue(3, 16'hF0F0, 16'h0F0F);
    issue(4, 16'hAAAA, 16'hAAAA);
    issue(4'd12, 16'h1234, 16'h5678);

    // MULU with start pulses while busy and during DONE, both ignored.
    issue(8, 16'h1234, 16'h0100);
    repeat (4) @(negedge clk);
    pulse(0, 16'd1, 16'd1);
    t = 0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("mul_done_seen", done, 1);
    alu_op = 4'd0; src_a = 16'd7; src_b = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ignored busy", busy, 0);
    chk("ignored result", result, 16'h3400);
    chk("ignored result_hi", result_hi, 16'h0012);

    issue(9, 16'd100, 16'd7);
    issue(9, 16'd5, 16'd0);
    issue(9, 16'hFFFF, 16'hFFFF);

    // Reset during DIVU iteration 5 aborts with no done.
    @(negedge clk);
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    pulse(9, 16'd100, 16'd7);
    repeat (4) @(negedge clk);
    reset = 1'b1; start = 1'b1; alu_op = 4'd0;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort result", result, 0);
    chk("abort result_hi", result_hi, 0);
    chk("abort flags", {zero, branch_le, div_by_zero, illegal_op}, 0);
    repeat (3) @(negedge clk);
    chk("abort still idle", busy, 0);
    issue(0, 16'd2, 16'd2);

    for (int i = 0; i < 20; i++)
      issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom));

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
